// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer and the
// execute-stage decode that routes opcodes to it.
package multdiv_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline-facing bundle of the multiply/divide sequencer, plus FSM state for observation.
interface multdiv_sequencer_if;
  import multdiv_pkg::*;

  // Handshake: a start (ctrl_MULT/ctrl_DIV) is accepted only while busy=0;
  // data_resultRDY is a one-cycle completion pulse with result/tag valid that cycle.
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_dest;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  result_dest;
  logic        busy;
  state_t      fsm_state;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_dest,
    input  data_result, data_exception, data_resultRDY, result_dest, busy, fsm_state
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_dest,
    output data_result, data_exception, data_resultRDY, result_dest, busy, fsm_state
  );

endinterface

// File: rtl/div_step_32.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module div_step_32 (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);
  logic [32:0] shifted;
  logic        unused_rem_msb;

  // After any completed step the remainder is below the divisor, so bit 32 is always clear.
  assign unused_rem_msb = rem[32];

  always_comb begin
    shifted  = {rem[31:0], quo[31]};
    rem_next = shifted;
    quo_next = {quo[30:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next    = shifted - {1'b0, divisor};
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/wallace_mult_32s.sv
// Signed 32x32 multiplier: low product word plus a flag when the full
// product does not fit in 32 signed bits.
module wallace_mult_32s (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        overflow
);
  logic signed [63:0] full;

  assign full     = $signed(a) * $signed(b);
  assign product  = full[31:0];
  assign overflow = (full[63:32] != {32{full[31]}});

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle mul/div unit beside the ALU: one registered multiplier pass or a
// 32-step restoring divide, stalling the pipeline via busy until the RDY pulse.
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  multdiv_sequencer_if.slave  bus
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [31:0]        op_a, op_b;
  logic [32:0]        rem;
  logic [31:0]        quo, div_abs;
  logic               sign_a, sign_b;
  logic [4:0]         dest_q;
  logic [31:0]        result_q;
  logic               exc_q;
  logic [4:0]         result_dest_q;
  logic [32:0]        rem_step;
  logic [31:0]        quo_step, prod_lo;
  logic               prod_ovf, can_start, start_mul, start_div;

  // Multiply has priority when both starts arrive together.
  assign can_start = (state == ST_IDLE) || (state == ST_DONE);
  assign start_mul = can_start && bus.ctrl_MULT;
  assign start_div = can_start && bus.ctrl_DIV && !bus.ctrl_MULT;

  wallace_mult_32s u_mult (.a(op_a), .b(op_b), .product(prod_lo), .overflow(prod_ovf));

  div_step_32 u_step (
    .rem(rem), .quo(quo), .divisor(div_abs), .rem_next(rem_step), .quo_next(quo_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_mul)      state_next = ST_MUL;
        else if (start_div) state_next = (bus.data_operandB == 32'd0) ? ST_DONE : ST_DIV;
        else                state_next = ST_IDLE;
      end
      ST_MUL:  state_next = ST_DONE;
      ST_DIV:  state_next = (count == CNT_W'(DIV_ITERS - 1)) ? ST_FIX : ST_DIV;
      ST_FIX:  state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      rem           <= '0;
      quo           <= '0;
      div_abs       <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      dest_q        <= '0;
      result_q      <= '0;
      exc_q         <= 1'b0;
      result_dest_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_mul) begin
            op_a   <= bus.data_operandA;
            op_b   <= bus.data_operandB;
            dest_q <= bus.ctrl_dest;
          end else if (start_div) begin
            dest_q  <= bus.ctrl_dest;
            count   <= '0;
            rem     <= '0;
            quo     <= abs32(bus.data_operandA);
            div_abs <= abs32(bus.data_operandB);
            sign_a  <= bus.data_operandA[31];
            sign_b  <= bus.data_operandB[31];
            if (bus.data_operandB == 32'd0) begin
              result_q      <= '0;
              exc_q         <= 1'b1;
              result_dest_q <= bus.ctrl_dest;
            end
          end
        end
        ST_MUL: begin
          result_q      <= prod_lo;
          exc_q         <= prod_ovf;
          result_dest_q <= dest_q;
        end
        ST_DIV: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + 1'b1;
        end
        ST_FIX: begin
          result_dest_q <= dest_q;
          // Same signs with bit 31 set only arises from -2^31 / -1.
          if (sign_a != sign_b) begin
            result_q <= ~quo + 32'd1;
            exc_q    <= 1'b0;
          end else if (quo[31]) begin
            result_q <= 32'h8000_0000;
            exc_q    <= 1'b1;
          end else begin
            result_q <= quo;
            exc_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.result_dest    = result_dest_q;
  assign bus.data_resultRDY = (state == ST_DONE);
  assign bus.busy           = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
  assign bus.fsm_state      = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed vector table, random
// operations against an arithmetic reference model, and reset/overlap sequences.
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multdiv_sequencer_if bus();
  multdiv_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res  = '0;
  logic [4:0]  last_dest = '0;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        b2b;
    int          inject;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic, division truncating toward zero.
  task automatic ref_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic exc);
    longint p;
    int     sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (m) begin
      p   = longint'(sa) * longint'(sb);
      res = p[31:0];
      exc = (p > 64'sh0000_0000_7fff_ffff) || (p < -64'sh0000_0000_8000_0000);
    end else if (sb == 0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      res = sa / sb;
      exc = 1'b0;
    end
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input int inject,
                        input logic [31:0] exp_res, input logic exp_exc, input string tag);
    int exp_lat, lat, busy_cnt;
    exp_lat = m ? 2 : ((b == 32'd0) ? 1 : 34);
    exp_q.push_back(exp_res);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_dest     = dest;
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
    bus.ctrl_dest     = 5'($urandom());
    lat = 1;
    busy_cnt = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 80) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (lat == inject) bus.ctrl_MULT = 1'b1;
      @(posedge clock); #1;
      bus.ctrl_MULT = 1'b0;
      lat++;
    end
    check({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, "_busy_at_rdy"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, bus.data_result, exp_q.pop_front());
    check({tag, "_exception"}, 32'(bus.data_exception), 32'(exp_exc));
    check({tag, "_dest"}, 32'(bus.result_dest), 32'(dest));
    last_res  = exp_res;
    last_dest = dest;
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      check("idle_rdy", 32'(bus.data_resultRDY), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("hold_result", bus.data_result, last_res);
      check("hold_dest", 32'(bus.result_dest), 32'(last_dest));
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hffff_ffff;
      2:       return 32'h8000_0000;
      3:       return 32'(int'($urandom_range(0, 20)) - 10);
      4:       return 32'($urandom_range(0, 65535));
      default: return $urandom();
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, bus.data_result, 32'd0);
    check({tag, "_exception"}, 32'(bus.data_exception), 32'd0);
    check({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd0);
    check({tag, "_dest"}, 32'(bus.result_dest), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_state"}, 32'(bus.fsm_state), 32'(ST_IDLE));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic        ee, m, d;
    logic [31:0] a, b;
    int          rdy_seen;

    tbl[0]  = '{1, 0, 32'd7,          32'hffff_fffa, 5'd3,  0, 0, 32'hffff_ffd6, 0};
    tbl[1]  = '{1, 0, 32'h0001_0000,  32'h0001_0000, 5'd4,  0, 0, 32'h0000_0000, 1};
    tbl[2]  = '{0, 1, 32'hffff_ff9c,  32'd7,         5'd5,  0, 5, 32'hffff_fff2, 0};
    tbl[3]  = '{0, 1, 32'd1234,       32'd0,         5'd6,  0, 0, 32'h0000_0000, 1};
    tbl[4]  = '{0, 1, 32'h8000_0000,  32'hffff_ffff, 5'd7,  0, 0, 32'h8000_0000, 1};
    tbl[5]  = '{0, 1, 32'd50,         32'hffff_fffb, 5'd8,  1, 0, 32'hffff_fff6, 0};
    tbl[6]  = '{1, 1, 32'd3,          32'd4,         5'd9,  0, 0, 32'h0000_000c, 0};
    tbl[7]  = '{1, 0, 32'h8000_0000,  32'hffff_ffff, 5'd10, 0, 0, 32'h8000_0000, 1};
    tbl[8]  = '{1, 0, 32'hffff_ffff,  32'hffff_ffff, 5'd11, 0, 0, 32'h0000_0001, 0};
    tbl[9]  = '{0, 1, 32'h7fff_ffff,  32'd1,         5'd12, 0, 0, 32'h7fff_ffff, 0};
    tbl[10] = '{0, 1, 32'h8000_0000,  32'd1,         5'd13, 0, 0, 32'h8000_0000, 0};
    tbl[11] = '{0, 1, 32'd3,          32'hffff_fff9, 5'd14, 0, 0, 32'h0000_0000, 0};
    tbl[12] = '{0, 1, 32'hffff_fff9,  32'hffff_fffe, 5'd15, 1, 0, 32'h0000_0003, 0};
    tbl[13] = '{0, 1, 32'd0,          32'd5,         5'd16, 0, 0, 32'h0000_0000, 0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_dest     = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    idle_gap(1);

    foreach (tbl[i]) begin
      if (!tbl[i].b2b) idle_gap(2);
      run_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].dest, tbl[i].inject,
             tbl[i].exp_res, tbl[i].exp_exc, $sformatf("vec%0d", i));
    end
    idle_gap(3);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       begin m = 1; d = 0; end
        3:       begin m = 1; d = 1; end
        default: begin m = 0; d = 1; end
      endcase
      a = rand_operand();
      b = rand_operand();
      ref_model(m, a, b, er, ee);
      if ($urandom_range(0, 3) != 0) idle_gap(1);
      run_op(m, d, a, b, 5'($urandom()), 0, er, ee, $sformatf("rnd%0d", n));
    end
    idle_gap(2);

    // Reset in the middle of a division: no completion may follow.
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd3;
    bus.ctrl_dest     = 5'd21;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("middiv_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1 || bus.busy === 1'b1) rdy_seen++;
    end
    check("post_reset_no_activity", rdy_seen, 0);
    check_reset_outputs("post_reset");

    last_res  = 32'd0;
    last_dest = 5'd0;
    run_op(1, 0, 32'd7, 32'hffff_fffa, 5'd22, 0, 32'hffff_ffd6, 1'b0, "recover");
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
